// File: rtl/multiplicador_seq_8bits_pkg.sv
// Shared ULA definitions: operand width and control-state encodings
// for the sequential shift-and-add multiplier.
package multiplicador_seq_8bits_pkg;

    localparam int unsigned LARGURA = 8;
    localparam int unsigned LARGURA_CONTADOR = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Index of the last shift-and-add step (counter value on the 8th step).
    localparam logic [LARGURA_CONTADOR-1:0] ULTIMO_PASSO = LARGURA_CONTADOR'(LARGURA - 1);

endpackage

// File: rtl/multiplicador_seq_8bits_somador.sv
// somador_8bits: ripple-carry adder with carry-in and carry-out,
// shared by the multiplier datapath for every partial-product step.
module somador_8bits
    import multiplicador_seq_8bits_pkg::*;
(
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic               C_in,
    output logic [LARGURA-1:0] S,
    output logic               C_out
);

    logic [LARGURA:0] carry;

    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = C_in;
        for (int unsigned i = 0; i < LARGURA; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
    end

    assign C_out = carry[LARGURA];

endmodule

// File: rtl/multiplicador_seq_8bits.sv
// Sequential 8x8 unsigned multiplier: shift-and-add over 8 steps,
// registered 16-bit product with a one-cycle valido pulse.
module multiplicador_seq_8bits
    import multiplicador_seq_8bits_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     A,
    input  logic [LARGURA-1:0]     B,
    output logic [2*LARGURA-1:0]   P,
    output logic                   valido,
    output logic                   ocupado
);

    estado_t estado, prox_estado;

    logic [LARGURA-1:0]          m;
    logic [LARGURA-1:0]          q;
    logic [LARGURA-1:0]          acumulador;
    logic                        c;
    logic [LARGURA_CONTADOR-1:0] contador;

    logic [LARGURA-1:0]   soma;
    logic                 c_out;
    logic [LARGURA-1:0]   parcial;
    logic                 c_parcial;
    logic [2*LARGURA-1:0] produto_prox;
    logic                 aceita;
    logic                 ultimo;

    somador_8bits u_somador (
        .A     (acumulador),
        .B     (m),
        .C_in  (1'b0),
        .S     (soma),
        .C_out (c_out)
    );

    always_comb begin
        if (q[0]) begin
            parcial   = soma;
            c_parcial = c_out;
        end else begin
            parcial   = acumulador;
            c_parcial = 1'b0;
        end
        produto_prox = {c_parcial, parcial, q[LARGURA-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // The FIM closing edge doubles as the first edge a new start can be
    // taken, so a held inicio yields one operation every 9 cycles.
    always_comb begin
        prox_estado = estado;
        aceita      = 1'b0;
        ultimo      = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (inicio) begin
                    prox_estado = CALCULA;
                    aceita      = 1'b1;
                end
            end
            CALCULA: begin
                if (contador == ULTIMO_PASSO) begin
                    prox_estado = FIM;
                    ultimo      = 1'b1;
                end
            end
            FIM: begin
                if (inicio) begin
                    prox_estado = CALCULA;
                    aceita      = 1'b1;
                end else begin
                    prox_estado = OCIOSO;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m          <= '0;
            q          <= '0;
            acumulador <= '0;
            c          <= 1'b0;
            contador   <= '0;
            P          <= '0;
            valido     <= 1'b0;
        end else begin
            valido <= ultimo;
            if (aceita) begin
                m          <= A;
                q          <= B;
                acumulador <= '0;
                c          <= 1'b0;
                contador   <= '0;
            end else if (estado == CALCULA) begin
                {acumulador, q} <= produto_prox;
                c               <= c_parcial;
                contador        <= contador + 1'b1;
            end
            if (ultimo) begin
                P <= produto_prox;
            end
        end
    end

    assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_multiplicador_seq_8bits.sv
// Directed bench for multiplicador_seq_8bits with hand-computed products.
module tb_multiplicador_seq_8bits;

    logic        clk;
    logic        rst;
    logic        inicio;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        valido;
    logic        ocupado;

    int erros;
    int checks;

    multiplicador_seq_8bits dut (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio),
        .A       (A),
        .B       (B),
        .P       (P),
        .valido  (valido),
        .ocupado (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Single operation with inicio pulsed for one edge; checks latency,
    // product, continuous ocupado and the return to idle.
    task automatic executa(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] esperado);
        int lat;
        int ocioso_cnt;
        int pulsos;
        @(negedge clk);
        A      = a;
        B      = b;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        A      = ~a;
        B      = ~b;
        lat        = 0;
        ocioso_cnt = (ocupado) ? 0 : 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (!ocupado) ocioso_cnt++;
            if (valido) break;
        end
        verifica({tag, "_latencia"}, lat, 8);
        verifica({tag, "_P"}, P, esperado);
        verifica({tag, "_ocupado_fim"}, ocupado, 1);
        verifica({tag, "_ocupado_continuo"}, ocioso_cnt, 0);
        pulsos = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (valido) pulsos++;
        end
        verifica({tag, "_valido_unico"}, pulsos, 0);
        verifica({tag, "_ocioso"}, ocupado, 0);
        verifica({tag, "_P_mantem"}, P, esperado);
    endtask

    initial begin
        int pulsos;
        int lat;
        int pos[$];

        erros  = 0;
        checks = 0;
        rst    = 1'b1;
        inicio = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        verifica("reset_P", P, 16'h0000);
        verifica("reset_valido", valido, 0);
        verifica("reset_ocupado", ocupado, 0);
        @(negedge clk);
        rst = 1'b0;

        executa("0F_0F", 8'h0F, 8'h0F, 16'h00E1);
        executa("FF_FF", 8'hFF, 8'hFF, 16'hFE01);
        executa("00_A5", 8'h00, 8'hA5, 16'h0000);
        executa("37_00", 8'h37, 8'h00, 16'h0000);
        executa("01_FF", 8'h01, 8'hFF, 16'h00FF);
        executa("80_80", 8'h80, 8'h80, 16'h4000);

        // Second request mid-operation with new operands must be ignored.
        @(negedge clk);
        A = 8'h12; B = 8'h34; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0; A = 8'h55; B = 8'hAA;
        pulsos = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (valido) begin
                pulsos++;
                verifica("ignora_P", P, 16'h03A8);
            end
        end
        verifica("ignora_pulsos", pulsos, 1);
        verifica("ignora_ocioso", ocupado, 0);

        // Reset mid-operation, with a coincident start that must be discarded.
        @(negedge clk);
        A = 8'hC8; B = 8'h03; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; inicio = 1'b1;
        @(posedge clk);
        #1;
        verifica("abort_P", P, 16'h0000);
        verifica("abort_valido", valido, 0);
        verifica("abort_ocupado", ocupado, 0);
        @(negedge clk);
        rst = 1'b0; inicio = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valido || ocupado) pulsos++;
        end
        verifica("abort_sem_atividade", pulsos, 0);
        executa("0A_0B", 8'h0A, 8'h0B, 16'h006E);

        // inicio held high: back-to-back operations every 9 cycles.
        @(negedge clk);
        A = 8'h02; B = 8'h03; inicio = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk);
            #1;
            if (valido) begin
                pos.push_back(n);
                verifica("continuo_P", P, 16'h0006);
            end
        end
        verifica("continuo_pulsos", pos.size(), 3);
        if (pos.size() == 3) begin
            verifica("continuo_pos0", pos[0], 8);
            verifica("continuo_pos1", pos[1], 17);
            verifica("continuo_pos2", pos[2], 26);
        end
        @(negedge clk);
        inicio = 1'b0;
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (!ocupado) break;
        end
        verifica("continuo_drena", ocupado, 0);
        verifica("continuo_P_final", P, 16'h0006);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
